// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
// The ovf signal exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic cin;
  logic in_valid;
  logic in_ready;
  logic cout;
  logic out_valid;
  logic out_ready;
`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf;
`endif
  modport master (
    output A, B, cin, in_valid, out_ready,
    input in_ready, S, cout, out_valid
`ifdef PIPELINED_ADDER_OVF_EN
    , input ovf
`endif
  );
  modport slave (
    input A, B, cin, in_valid, out_ready,
    output in_ready, S, cout, out_valid
`ifdef PIPELINED_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep slice-wise ripple adder with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_adder_if.slave bus_io
);
  localparam int W = WIDTH / STAGES;
  logic adv;
  logic [STAGES:0] v_q;
  logic [STAGES:0] c_q;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [W:0] slc_d [STAGES];
  assign adv              = bus_io.out_ready | ~v_q[STAGES];
  assign bus_io.in_ready  = adv;
  assign bus_io.S         = s_q[STAGES];
  assign bus_io.cout      = c_q[STAGES];
  assign bus_io.out_valid = v_q[STAGES];
  // level k holds operands for stage k; stage k writes slice k into level k+1
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    assign slc_d[k] = {1'b0, a_q[k][k*W +: W]} + {1'b0, b_q[k][k*W +: W]} + (W+1)'(c_q[k]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      c_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int i = 0; i <= STAGES; i++) s_q[i] <= '0;
    end else if (adv) begin
      v_q    <= {v_q[STAGES-1:0], bus_io.in_valid};
      c_q[0] <= bus_io.cin;
      a_q[0] <= bus_io.A;
      b_q[0] <= bus_io.B;
      s_q[0] <= '0;
      for (int i = 1; i < STAGES; i++) begin
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        c_q[i+1]             <= slc_d[i][W];
        s_q[i+1]             <= s_q[i];
        s_q[i+1][i*W +: W]   <= slc_d[i][W-1:0];
      end
    end
  end
`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_q;
  // carry into the MSB is a^b^sum at that bit
  always_ff @(posedge clk) begin
    if (!rst) ovf_q <= 1'b0;
    else if (adv) ovf_q <= a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                         ^ slc_d[STAGES-1][W-1] ^ slc_d[STAGES-1][W];
  end
  assign bus_io.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of latency, throughput, stall, reset and bubbles.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vc [8];
  logic [15:0] es [8];
  logic        ec [8];
  pipelined_adder_if #(.WIDTH(16)) bus ();
  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (.clk(clk), .rst(rst), .bus_io(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    bus.A = a;
    bus.B = b;
    bus.cin = c;
    bus.in_valid = v;
  endtask
  initial begin
    va = '{16'h1000, 16'hDEAD, 16'hF000, 16'hDEAD, 16'h7FFF, 16'hDEAD, 16'hABCD, 16'hDEAD};
    vb = '{16'h0234, 16'hBEEF, 16'h1000, 16'hBEEF, 16'h0001, 16'hBEEF, 16'h1111, 16'hBEEF};
    vc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    es = '{16'h1234, 16'h0, 16'h0000, 16'h0, 16'h8001, 16'h0, 16'hBCDE, 16'h0};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_s", 32'(bus.S), 0);
    check("rst_cout", 32'(bus.cout), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    // all-ones wrap, exact latency
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wrap_early", 32'(bus.out_valid), 0);
    end
    step();
    check("wrap_valid", 32'(bus.out_valid), 1);
    check("wrap_s", 32'(bus.S), 0);
    check("wrap_cout", 32'(bus.cout), 1);
    step();
    check("wrap_drain", 32'(bus.out_valid), 0);
    // back-to-back
    drive(16'h0001, 16'h0002, 1'b0, 1'b1);
    step();
    drive(16'h1234, 16'h4321, 1'b1, 1'b1);
    step();
    drive(16'h8000, 16'h8000, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("b2b0_valid", 32'(bus.out_valid), 1);
    check("b2b0_s", 32'(bus.S), 32'h3);
    check("b2b0_cout", 32'(bus.cout), 0);
    step();
    check("b2b1_valid", 32'(bus.out_valid), 1);
    check("b2b1_s", 32'(bus.S), 32'h5556);
    check("b2b1_cout", 32'(bus.cout), 0);
    step();
    check("b2b2_valid", 32'(bus.out_valid), 1);
    check("b2b2_s", 32'(bus.S), 32'h0);
    check("b2b2_cout", 32'(bus.cout), 1);
    step();
    check("b2b_drain", 32'(bus.out_valid), 0);
    // stall with a held pending operation
    drive(16'h0100, 16'h0200, 1'b0, 1'b1);
    step();
    drive(16'hFFFE, 16'h0003, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("stall_x_s", 32'(bus.S), 32'h0300);
    bus.out_ready = 1'b0;
    drive(16'h00FF, 16'h0001, 1'b1, 1'b1);
    #1;
    check("stall_in_ready", 32'(bus.in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_s", 32'(bus.S), 32'h0300);
      check("stall_cout", 32'(bus.cout), 0);
      check("stall_rdy", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("resume_y_valid", 32'(bus.out_valid), 1);
    check("resume_y_s", 32'(bus.S), 32'h0001);
    check("resume_y_cout", 32'(bus.cout), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("resume_gap", 32'(bus.out_valid), 0);
    end
    step();
    check("resume_z_valid", 32'(bus.out_valid), 1);
    check("resume_z_s", 32'(bus.S), 32'h0101);
    check("resume_z_cout", 32'(bus.cout), 0);
    step();
    check("resume_drain", 32'(bus.out_valid), 0);
    // reset with two operations in flight
    drive(16'h0005, 16'h0006, 1'b0, 1'b1);
    step();
    drive(16'h0007, 16'h0008, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_s", 32'(bus.S), 0);
    check("midrst_cout", 32'(bus.cout), 0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("midrst_quiet", 32'(bus.out_valid), 0);
    end
    // alternating bubbles
    for (int t = 0; t < 12; t++) begin
      if (t < 8) drive(va[t], vb[t], vc[t], (t % 2) == 0);
      else bus.in_valid = 1'b0;
      step();
      if (t >= 4) begin
        check("alt_valid", 32'(bus.out_valid), ((t - 4) % 2) == 0);
        if (((t - 4) % 2) == 0) begin
          check("alt_s", 32'(bus.S), 32'(es[t-4]));
          check("alt_cout", 32'(bus.cout), 32'(ec[t-4]));
        end
      end
    end
`ifdef PIPELINED_ADDER_OVF_EN
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step();
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("ovf_pos_ovf", 32'(bus.ovf), 1);
    check("ovf_pos_s", 32'(bus.S), 32'h8000);
    check("ovf_pos_cout", 32'(bus.cout), 0);
    step();
    check("ovf_wrap_ovf", 32'(bus.ovf), 0);
    check("ovf_wrap_cout", 32'(bus.cout), 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter: WIDTH, 16, operand/sum width in bits; SHALL be >= 2.
REQ-002 Parameter: STAGES, 4, pipeline depth; SHALL be >= 1 and SHALL divide WIDTH exactly (slice width W = WIDTH/STAGES).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets the block).
REQ-005 A  input  WIDTH  unsigned operand A.
REQ-006 B  input  WIDTH  unsigned operand B.
REQ-007 cin  input  1  carry-in.
REQ-008 in_valid  input  1  A/B/cin valid this cycle.
REQ-009 in_ready  output  1  block accepts an operation this cycle.
REQ-010 S  output  WIDTH  sum, registered.
REQ-011 cout  output  1  carry-out of bit WIDTH-1, registered.
REQ-012 out_valid  output  1  S/cout hold a valid result.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add bit slice [k*W+W-1 : k*W] of A and B plus the carry registered by stage k-1 (cin for stage 0), ripple-carry within the slice.
REQ-015 Unconsumed operand slices SHALL be skewed forward and completed sum slices deskewed in registers, so S, cout and out_valid emerge together.
REQ-016 Latency: an operation accepted at edge n SHALL appear on S/cout with out_valid=1 after edge n+STAGES, if no stall occurs.
REQ-017 Advance enable: adv = out_ready | ~out_valid; in_ready SHALL equal adv, combinationally.
REQ-018 On adv=1 every stage (data, carry, valid bit) SHALL shift one position; stage-0 valid loads in_valid.
REQ-019 On adv=0 all pipeline registers and outputs SHALL hold; S/cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 Throughput: one operation per cycle when out_ready is held 1; bubbles (in_valid=0) SHALL propagate as valid=0 slots without disturbing neighbouring results.
REQ-021 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-022 Result SHALL equal {cout,S} = A + B + cin modulo 2^(WIDTH+1); wrap-around at all-ones SHALL produce S=0, cout=1.
REQ-023 in_valid=1 while in_ready=0 SHALL be ignored; the source holds the operation.
REQ-024 Output transfer occurs when out_valid & out_ready; simultaneous transfer and new acceptance in the same cycle SHALL be supported.

Reset
REQ-025 With rst==0 at a rising edge, all valid bits, carries, skew/deskew registers, S, cout and out_valid SHALL be cleared to 0.
REQ-026 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after reset release.
REQ-027 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 Macro PIPELINED_ADDER_OVF_EN defined: extra output ovf (output, 1) registered alongside S, = signed two's-complement overflow (carry into MSB XOR carry out of MSB), cleared by reset, held on stall.
REQ-029 Macro undefined: no ovf port and no related logic; all other behaviour identical.

Verification (WIDTH=16, STAGES=4)
REQ-030 A=16'hFFFF, B=16'h0001, cin=0, out_ready=1 -> S=16'h0000, cout=1, out_valid=1 exactly 4 cycles after acceptance.
REQ-031 Back-to-back 1+2 (cin=0), 16'h1234+16'h4321 (cin=1), 16'h8000+16'h8000 (cin=0) -> on consecutive cycles S=3/cout=0, S=16'h5556/cout=0, S=0/cout=1.
REQ-032 Result valid, out_ready=0 for 5 cycles -> S/cout/out_valid unchanged, in_ready=0, no acceptance; out_ready=1 -> results resume in order, none lost.
REQ-033 Two operations in flight, rst=0 for one edge -> out_valid=0, S=0, cout=0 next cycle; no result emerges for the next 4 cycles.
REQ-034 Alternating in_valid 1/0 for 8 cycles -> out_valid toggles 1/0 after 4-cycle latency, sums correct for every valid slot.
REQ-035 With PIPELINED_ADDER_OVF_EN: 16'h7FFF+16'h0001 -> ovf=1, S=16'h8000, cout=0; 16'hFFFF+16'h0001 -> ovf=0, cout=1.
